// File: rtl/branch_issue_scheduler.sv
// branch_issue_scheduler: holds branch/jump/LUI/AUIPC micro-ops until both
// source tags are ready, then issues one per cycle to the branch unit.
// Optional macro BRANCH_SCHED_AGE_SELECT_EN: oldest-ready select via an
// age matrix; when undefined, the lowest-index ready entry is selected.
module branch_issue_scheduler #(
  parameter int ENTRIES   = 8,
  parameter int PAYLOAD_W = 128
) (
  input  logic                         cpu_clock_i,
  input  logic                         cpu_reset_i,
  input  logic                         flush_i,
  input  logic                         enq_valid_i,
  output logic                         enq_ready_o,
  input  logic [5:0]                   enq_rs1_i,
  input  logic                         enq_rs1_rdy_i,
  input  logic [5:0]                   enq_rs2_i,
  input  logic                         enq_rs2_rdy_i,
  input  logic [PAYLOAD_W-1:0]         enq_payload_i,
  input  logic                         wk0_valid_i,
  input  logic [5:0]                   wk0_tag_i,
  input  logic                         wk1_valid_i,
  input  logic [5:0]                   wk1_tag_i,
  output logic                         iss_valid_o,
  output logic [5:0]                   iss_rs1_o,
  output logic [5:0]                   iss_rs2_o,
  output logic [PAYLOAD_W-1:0]         iss_payload_o,
  output logic [$clog2(ENTRIES):0]     count_o
);

  localparam int CNT_W = $clog2(ENTRIES) + 1;
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_rdy1;
  logic [ENTRIES-1:0]   r_rdy2;
  logic [5:0]           r_rs1 [ENTRIES];
  logic [5:0]           r_rs2 [ENTRIES];
  logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
  logic [CNT_W-1:0]     r_count;

  logic                 r_iss_valid;
  logic [5:0]           r_iss_rs1;
  logic [5:0]           r_iss_rs2;
  logic [PAYLOAD_W-1:0] r_iss_payload;

  logic                 w_enq_ready;
  logic                 w_enq_fire;
  logic [IDX_W-1:0]     w_free_idx;
  logic                 w_free_found;
  logic [ENTRIES-1:0]   w_cand;
  logic [IDX_W-1:0]     w_sel_idx;
  logic                 w_sel_found;
  logic                 w_enq_rdy1;
  logic                 w_enq_rdy2;

  // True when either valid wakeup broadcast carries the given tag.
  function automatic logic wk_hit(input logic [5:0] tag);
    return (wk0_valid_i && (wk0_tag_i == tag)) ||
           (wk1_valid_i && (wk1_tag_i == tag));
  endfunction

  // Admission: based on registered occupancy only, so an issue in the same
  // cycle never makes room for a concurrent enqueue.
  always_comb begin
    w_enq_ready = (r_count < CNT_W'(ENTRIES));
    w_enq_fire  = enq_valid_i && w_enq_ready && !flush_i;
    w_enq_rdy1  = enq_rs1_rdy_i || (enq_rs1_i == 6'd0) || wk_hit(enq_rs1_i);
    w_enq_rdy2  = enq_rs2_rdy_i || (enq_rs2_i == 6'd0) || wk_hit(enq_rs2_i);
  end

  // Lowest-index free slot for the incoming op.
  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  // Entries eligible for issue, from registered ready state only.
  always_comb begin
    w_cand = r_valid & r_rdy1 & r_rdy2;
  end

`ifdef BRANCH_SCHED_AGE_SELECT_EN
  // r_age[j][i] set means slot j was dispatched before slot i.
  logic [ENTRIES-1:0] r_age [ENTRIES];

  // Oldest-ready select: a candidate is chosen when no other candidate is older.
  always_comb begin
    logic w_blocked;
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      w_blocked = 1'b0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        if ((j != i) && w_cand[j] && r_age[j][i]) w_blocked = 1'b1;
      end
      if (w_cand[i] && !w_blocked && !w_sel_found) begin
        w_sel_idx   = IDX_W'(i);
        w_sel_found = 1'b1;
      end
    end
  end

  // Age matrix: a new slot is younger than every currently valid slot.
  // Stale rows/columns of freed slots are harmless since only candidates compare.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i || flush_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) r_age[i] <= '0;
    end else if (w_enq_fire) begin
      r_age[w_free_idx] <= '0;
      for (int unsigned j = 0; j < ENTRIES; j++) begin
        if (IDX_W'(j) != w_free_idx) r_age[j][w_free_idx] <= r_valid[j];
      end
    end
  end
`else
  // Lowest-index ready select.
  always_comb begin
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (w_cand[i] && !w_sel_found) begin
        w_sel_idx   = IDX_W'(i);
        w_sel_found = 1'b1;
      end
    end
  end
`endif

  // Control state: valid/ready bits, occupancy and the registered issue port.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      r_valid       <= '0;
      r_rdy1        <= '0;
      r_rdy2        <= '0;
      r_count       <= '0;
      r_iss_valid   <= 1'b0;
      r_iss_rs1     <= '0;
      r_iss_rs2     <= '0;
      r_iss_payload <= '0;
    end else if (flush_i) begin
      r_valid     <= '0;
      r_count     <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (r_valid[i]) begin
          if (wk_hit(r_rs1[i])) r_rdy1[i] <= 1'b1;
          if (wk_hit(r_rs2[i])) r_rdy2[i] <= 1'b1;
        end
      end
      if (w_sel_found) r_valid[w_sel_idx] <= 1'b0;
      if (w_enq_fire) begin
        r_valid[w_free_idx] <= 1'b1;
        r_rdy1[w_free_idx]  <= w_enq_rdy1;
        r_rdy2[w_free_idx]  <= w_enq_rdy2;
      end
      r_count     <= r_count + CNT_W'(w_enq_fire) - CNT_W'(w_sel_found);
      r_iss_valid <= w_sel_found;
      if (w_sel_found) begin
        r_iss_rs1     <= r_rs1[w_sel_idx];
        r_iss_rs2     <= r_rs2[w_sel_idx];
        r_iss_payload <= r_payload[w_sel_idx];
      end
    end
  end

  // Entry data storage; qualified by the valid bits, so no reset needed.
  always_ff @(posedge cpu_clock_i) begin
    if (w_enq_fire) begin
      r_rs1[w_free_idx]     <= enq_rs1_i;
      r_rs2[w_free_idx]     <= enq_rs2_i;
      r_payload[w_free_idx] <= enq_payload_i;
    end
  end

  // Output drive.
  always_comb begin
    enq_ready_o   = w_enq_ready;
    iss_valid_o   = r_iss_valid;
    iss_rs1_o     = r_iss_rs1;
    iss_rs2_o     = r_iss_rs2;
    iss_payload_o = r_iss_payload;
    count_o       = r_count;
  end

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Directed and scoreboarded random bench for branch_issue_scheduler.
module tb_branch_issue_scheduler;

  localparam int MAXID = 2048;

  logic         cpu_clock_i;
  logic         cpu_reset_i;
  logic         flush_i;
  logic         enq_valid_i;
  logic         enq_ready_o;
  logic [5:0]   enq_rs1_i;
  logic         enq_rs1_rdy_i;
  logic [5:0]   enq_rs2_i;
  logic         enq_rs2_rdy_i;
  logic [127:0] enq_payload_i;
  logic         wk0_valid_i;
  logic [5:0]   wk0_tag_i;
  logic         wk1_valid_i;
  logic [5:0]   wk1_tag_i;
  logic         iss_valid_o;
  logic [5:0]   iss_rs1_o;
  logic [5:0]   iss_rs2_o;
  logic [127:0] iss_payload_o;
  logic [3:0]   count_o;

  int n_checks = 0;
  int n_errors = 0;

  bit         m_pend [MAXID];
  logic [5:0] m_t1   [MAXID];
  logic [5:0] m_t2   [MAXID];
  bit         m_r1   [MAXID];
  bit         m_r2   [MAXID];
  int         m_count = 0;
  int         next_id = 0;

  localparam logic [95:0] RND_HI = 96'hC0FFEE00_5A5A5A5A_12345678;

  branch_issue_scheduler #(.ENTRIES(8), .PAYLOAD_W(128)) dut (
    .cpu_clock_i   (cpu_clock_i),
    .cpu_reset_i   (cpu_reset_i),
    .flush_i       (flush_i),
    .enq_valid_i   (enq_valid_i),
    .enq_ready_o   (enq_ready_o),
    .enq_rs1_i     (enq_rs1_i),
    .enq_rs1_rdy_i (enq_rs1_rdy_i),
    .enq_rs2_i     (enq_rs2_i),
    .enq_rs2_rdy_i (enq_rs2_rdy_i),
    .enq_payload_i (enq_payload_i),
    .wk0_valid_i   (wk0_valid_i),
    .wk0_tag_i     (wk0_tag_i),
    .wk1_valid_i   (wk1_valid_i),
    .wk1_tag_i     (wk1_tag_i),
    .iss_valid_o   (iss_valid_o),
    .iss_rs1_o     (iss_rs1_o),
    .iss_rs2_o     (iss_rs2_o),
    .iss_payload_o (iss_payload_o),
    .count_o       (count_o)
  );

  initial cpu_clock_i = 1'b0;
  always #5 cpu_clock_i = ~cpu_clock_i;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock_i);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    enq_valid_i   = 1'b0;
    enq_rs1_i     = '0;
    enq_rs1_rdy_i = 1'b0;
    enq_rs2_i     = '0;
    enq_rs2_rdy_i = 1'b0;
    enq_payload_i = '0;
    wk0_valid_i   = 1'b0;
    wk0_tag_i     = '0;
    wk1_valid_i   = 1'b0;
    wk1_tag_i     = '0;
  endtask

  task automatic set_enq(input logic [5:0] t1, input logic r1, input logic [5:0] t2,
                         input logic r2, input logic [127:0] pl);
    enq_valid_i   = 1'b1;
    enq_rs1_i     = t1;
    enq_rs1_rdy_i = r1;
    enq_rs2_i     = t2;
    enq_rs2_rdy_i = r2;
    enq_payload_i = pl;
  endtask

  function automatic bit hit(input logic w0v, input logic [5:0] w0t,
                             input logic w1v, input logic [5:0] w1t, input logic [5:0] t);
    return (w0v && w0t == t) || (w1v && w1t == t);
  endfunction

  // One cycle against the scoreboard: drive, clock, then verify issue and occupancy.
  task automatic step_model(input logic ev, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2, input logic fl,
                            input logic w0v, input logic [5:0] w0t,
                            input logic w1v, input logic [5:0] w1t);
    bit acc;
    bit any_rdy;
    int id;
    flush_i       = fl;
    enq_valid_i   = ev;
    enq_rs1_i     = t1;
    enq_rs1_rdy_i = r1;
    enq_rs2_i     = t2;
    enq_rs2_rdy_i = r2;
    enq_payload_i = {RND_HI, 32'(next_id)};
    wk0_valid_i   = w0v;
    wk0_tag_i     = w0t;
    wk1_valid_i   = w1v;
    wk1_tag_i     = w1t;
    acc = ev && (m_count < 8) && !fl && (next_id < MAXID);
    any_rdy = 1'b0;
    for (int i = 0; i < next_id; i++)
      if (m_pend[i] && m_r1[i] && m_r2[i]) any_rdy = 1'b1;
    tick();
    if (fl) begin
      check_eq("rnd_flush_iss_valid", iss_valid_o, 1'b0);
      for (int i = 0; i < next_id; i++) m_pend[i] = 1'b0;
      m_count = 0;
    end else begin
      check_eq("rnd_issue_when_ready", iss_valid_o, any_rdy);
      if (iss_valid_o) begin
        id = int'(iss_payload_o[31:0]);
        check_eq("rnd_iss_payload_hi", iss_payload_o[127:32], RND_HI);
        check_eq("rnd_iss_id_range", (id < next_id), 1'b1);
        if (id < next_id) begin
          check_eq("rnd_iss_pending", m_pend[id], 1'b1);
          check_eq("rnd_iss_ready", m_r1[id] && m_r2[id], 1'b1);
          check_eq("rnd_iss_rs1", iss_rs1_o, m_t1[id]);
          check_eq("rnd_iss_rs2", iss_rs2_o, m_t2[id]);
          if (m_pend[id]) begin
            m_pend[id] = 1'b0;
            m_count--;
          end
        end
      end
      for (int i = 0; i < next_id; i++) begin
        if (m_pend[i]) begin
          if (hit(w0v, w0t, w1v, w1t, m_t1[i])) m_r1[i] = 1'b1;
          if (hit(w0v, w0t, w1v, w1t, m_t2[i])) m_r2[i] = 1'b1;
        end
      end
      if (acc) begin
        m_pend[next_id] = 1'b1;
        m_t1[next_id]   = t1;
        m_t2[next_id]   = t2;
        m_r1[next_id]   = r1 || (t1 == 6'd0) || hit(w0v, w0t, w1v, w1t, t1);
        m_r2[next_id]   = r2 || (t2 == 6'd0) || hit(w0v, w0t, w1v, w1t, t2);
        next_id++;
        m_count++;
      end
    end
    check_eq("rnd_count", count_o, m_count);
    check_eq("rnd_enq_ready", enq_ready_o, (m_count < 8));
  endtask

  logic [127:0] exp_order [3];

  initial begin
    idle();
    cpu_reset_i = 1'b1;
    tick();
    tick();
    check_eq("rst_iss_valid", iss_valid_o, 1'b0);
    check_eq("rst_iss_rs1", iss_rs1_o, 6'd0);
    check_eq("rst_iss_rs2", iss_rs2_o, 6'd0);
    check_eq("rst_iss_payload", iss_payload_o, 128'd0);
    check_eq("rst_count", count_o, 4'd0);
    check_eq("rst_enq_ready", enq_ready_o, 1'b1);
    cpu_reset_i = 1'b0;

    // Wakeup-driven issue: tags 5/0, rs1 woken three cycles after dispatch.
    set_enq(6'd5, 1'b0, 6'd0, 1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    tick();
    idle();
    check_eq("t1_count", count_o, 4'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1_wait_no_issue", iss_valid_o, 1'b0);
    end
    wk0_valid_i = 1'b1;
    wk0_tag_i   = 6'd5;
    tick();
    idle();
    check_eq("t1_wk_plus1", iss_valid_o, 1'b0);
    tick();
    check_eq("t1_wk_plus2_valid", iss_valid_o, 1'b1);
    check_eq("t1_rs1", iss_rs1_o, 6'd5);
    check_eq("t1_rs2", iss_rs2_o, 6'd0);
    check_eq("t1_payload", iss_payload_o, 128'h01234567_89ABCDEF_FEDCBA98_76543210);
    check_eq("t1_count_after", count_o, 4'd0);
    tick();
    check_eq("t1_single_issue", iss_valid_o, 1'b0);

    // Full queue: issue and concurrent offer in the same cycle.
    for (int k = 0; k < 8; k++) begin
      set_enq(6'(10 + k), 1'b0, 6'd0, 1'b0, 128'(100 + k));
      tick();
    end
    idle();
    check_eq("t2_full_count", count_o, 4'd8);
    check_eq("t2_full_ready", enq_ready_o, 1'b0);
    wk0_valid_i = 1'b1;
    wk0_tag_i   = 6'd10;
    tick();
    idle();
    set_enq(6'd0, 1'b1, 6'd0, 1'b1, 128'hDEAD);
    tick();
    idle();
    check_eq("t2_issue_valid", iss_valid_o, 1'b1);
    check_eq("t2_issue_rs1", iss_rs1_o, 6'd10);
    check_eq("t2_issue_payload", iss_payload_o, 128'd100);
    check_eq("t2_count_7", count_o, 4'd7);
    check_eq("t2_ready_again", enq_ready_o, 1'b1);
    tick();
    check_eq("t2_rejected_never_issues", iss_valid_o, 1'b0);
    flush_i = 1'b1;
    tick();
    idle();
    check_eq("t2_flush_count", count_o, 4'd0);

    // Same-cycle wakeup and enqueue of tag 12.
    set_enq(6'd12, 1'b0, 6'd0, 1'b0, 128'h00C0_FFEE);
    wk1_valid_i = 1'b1;
    wk1_tag_i   = 6'd12;
    tick();
    idle();
    check_eq("t3_plus1", iss_valid_o, 1'b0);
    tick();
    check_eq("t3_plus2_valid", iss_valid_o, 1'b1);
    check_eq("t3_rs1", iss_rs1_o, 6'd12);
    check_eq("t3_payload", iss_payload_o, 128'h00C0_FFEE);
    tick();

    // Flush with four ready entries and an offer in the flush cycle.
    for (int k = 0; k < 4; k++) begin
      set_enq(6'd20, 1'b0, 6'd20, 1'b0, 128'(200 + k));
      tick();
    end
    idle();
    wk0_valid_i = 1'b1;
    wk0_tag_i   = 6'd20;
    tick();
    idle();
    check_eq("t4_held_count", count_o, 4'd4);
    flush_i = 1'b1;
    set_enq(6'd0, 1'b1, 6'd0, 1'b1, 128'd300);
    tick();
    idle();
    check_eq("t4_flush_iss_valid", iss_valid_o, 1'b0);
    check_eq("t4_flush_count", count_o, 4'd0);
    check_eq("t4_flush_ready", enq_ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t4_no_late_issue", iss_valid_o, 1'b0);
    end

    // Selection order: P1(slot1), P2(slot2) older than P3 refilling slot0.
`ifdef BRANCH_SCHED_AGE_SELECT_EN
    exp_order[0] = 128'd401;
    exp_order[1] = 128'd402;
    exp_order[2] = 128'd403;
`else
    exp_order[0] = 128'd403;
    exp_order[1] = 128'd401;
    exp_order[2] = 128'd402;
`endif
    set_enq(6'd1, 1'b0, 6'd0, 1'b0, 128'd400);
    tick();
    set_enq(6'd2, 1'b0, 6'd0, 1'b0, 128'd401);
    tick();
    set_enq(6'd3, 1'b0, 6'd0, 1'b0, 128'd402);
    tick();
    idle();
    wk0_valid_i = 1'b1;
    wk0_tag_i   = 6'd1;
    tick();
    idle();
    tick();
    check_eq("t5_first_valid", iss_valid_o, 1'b1);
    check_eq("t5_first_payload", iss_payload_o, 128'd400);
    set_enq(6'd2, 1'b0, 6'd0, 1'b0, 128'd403);
    tick();
    idle();
    check_eq("t5_count3", count_o, 4'd3);
    wk0_valid_i = 1'b1;
    wk0_tag_i   = 6'd2;
    wk1_valid_i = 1'b1;
    wk1_tag_i   = 6'd3;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t5_order_valid", iss_valid_o, 1'b1);
      check_eq("t5_order_payload", iss_payload_o, exp_order[k]);
    end
    tick();
    check_eq("t5_done_valid", iss_valid_o, 1'b0);
    check_eq("t5_done_count", count_o, 4'd0);

    // Random traffic against the scoreboard, then drain.
    for (int c = 0; c < 1000; c++) begin
      step_model(($urandom % 100) < 55,
                 6'($urandom % 12), ($urandom % 4) == 0,
                 6'($urandom % 12), ($urandom % 4) == 0,
                 ($urandom % 60) == 0,
                 ($urandom % 2) == 1, 6'($urandom % 12),
                 ($urandom % 2) == 1, 6'($urandom % 12));
    end
    for (int c = 0; c < 24; c++) begin
      step_model(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0,
                 (c < 6), 6'(2 * (c % 6)), (c < 6), 6'(2 * (c % 6) + 1));
    end
    check_eq("drain_count", count_o, 4'd0);
    check_eq("drain_iss_valid", iss_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
